// File: rtl/cmd_seq_player.sv
// cmd_seq_player
//   Plays a loaded list of Knight command words into RemoteComm, one at a time.
//   Each command waits for its response byte, which is checked against POS_ACK.
//   Bad responses are counted, and the first failing slot is remembered.
//   A per-command watchdog ends the run if RemoteComm stalls.
//   The run ends with a one-clock done pulse and a pass flag.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   load_we/addr/data        command memory write port (only accepted while idle)
//   num_cmds, start, abort   playback control
//   cmd, snd_cmd             command word and 1-clk send strobe to RemoteComm
//   cmd_snt, resp_rdy, resp  RemoteComm status and response byte
//   busy, done, pass         run status
//   err_cnt, fail_idx        bad-response count, first failing slot
//   tmo_err, cur_idx         watchdog expiry flag, slot in flight
module cmd_seq_player #(
   parameter int unsigned       DEPTH       = 16,
   parameter int unsigned       CMD_W       = 16,
   parameter int unsigned       RESP_W      = 8,
   parameter logic [RESP_W-1:0] POS_ACK     = 8'hA5,
   parameter int unsigned       TMO_CYC     = 1_000_000,
   parameter bit                STOP_ON_ERR = 1'b1,
   localparam int unsigned      AW          = $clog2(DEPTH),
   localparam int unsigned      NW          = AW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_we,
   input  logic [AW-1:0]     load_addr,
   input  logic [CMD_W-1:0]  load_data,
   input  logic [NW-1:0]     num_cmds,
   input  logic              start,
   input  logic              abort,
   output logic [CMD_W-1:0]  cmd,
   output logic              snd_cmd,
   input  logic              cmd_snt,
   input  logic              resp_rdy,
   input  logic [RESP_W-1:0] resp,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [NW-1:0]     err_cnt,
   output logic [AW-1:0]     fail_idx,
   output logic              tmo_err,
   output logic [AW-1:0]     cur_idx
);

   localparam int unsigned TW = $clog2(TMO_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_SNT,
      S_WAIT_RESP,
      S_NEXT,
      S_FIN
   } state_t;

   state_t           st;
   logic [CMD_W-1:0] mem [DEPTH];
   logic [NW-1:0]    num_q;
   logic [TW-1:0]    wdog;
   logic             cur_bad;
   logic             aborted;

   logic idle_c;
   logic waiting_c;
   logic abort_c;
   logic take_resp_c;
   logic resp_bad_c;
   logic wdog_exp_c;
   logic last_c;

   // Decode of the current state and handshake events
   assign idle_c      = (st == S_IDLE);
   assign waiting_c   = (st == S_WAIT_SNT) || (st == S_WAIT_RESP);
   // Abort is meaningful only while a run is active and not already finishing
   assign abort_c     = abort && !idle_c && (st != S_FIN);
   // A response arriving in the abort clock is dropped
   assign take_resp_c = waiting_c && resp_rdy && !abort_c;
   assign resp_bad_c  = (resp != POS_ACK);
   // Counter holds TMO_CYC-1 in the clock that would make it reach TMO_CYC
   assign wdog_exp_c  = waiting_c && !resp_rdy && (wdog == TW'(TMO_CYC - 1));
   assign last_c      = ({1'b0, cur_idx} == (num_q - NW'(1)));

   // Command memory; contents survive reset
   always_ff @(posedge clk) begin
      if (!rst && load_we && idle_c)
         mem[load_addr] <= load_data;
   end

   // Playback sequencer with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= S_IDLE;
         num_q    <= '0;
         wdog     <= '0;
         cur_bad  <= 1'b0;
         aborted  <= 1'b0;
         cmd      <= '0;
         snd_cmd  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         err_cnt  <= '0;
         fail_idx <= '0;
         tmo_err  <= 1'b0;
         cur_idx  <= '0;
      end else begin
         snd_cmd <= 1'b0;
         done    <= 1'b0;

         if (abort_c) begin
            aborted <= 1'b1;
            st      <= S_FIN;
         end else begin
            unique case (st)
               S_IDLE: begin
                  if (start && !abort) begin
                     num_q    <= num_cmds;
                     cur_idx  <= '0;
                     err_cnt  <= '0;
                     fail_idx <= '0;
                     tmo_err  <= 1'b0;
                     aborted  <= 1'b0;
                     cur_bad  <= 1'b0;
                     pass     <= 1'b0;
                     if (num_cmds == '0) begin
                        st <= S_FIN;
                     end else begin
                        busy <= 1'b1;
                        st   <= S_SEND;
                     end
                  end
               end

               S_SEND: begin
                  cmd     <= mem[cur_idx];
                  snd_cmd <= 1'b1;
                  wdog    <= '0;
                  cur_bad <= 1'b0;
                  st      <= S_WAIT_SNT;
               end

               // Response may overtake cmd_snt; accept it straight away
               S_WAIT_SNT: begin
                  wdog <= wdog + TW'(1);
                  if (resp_rdy)
                     st <= S_NEXT;
                  else if (wdog_exp_c)
                     st <= S_FIN;
                  else if (cmd_snt)
                     st <= S_WAIT_RESP;
               end

               S_WAIT_RESP: begin
                  wdog <= wdog + TW'(1);
                  if (resp_rdy)
                     st <= S_NEXT;
                  else if (wdog_exp_c)
                     st <= S_FIN;
               end

               S_NEXT: begin
                  if (cur_bad && STOP_ON_ERR) begin
                     st <= S_FIN;
                  end else if (last_c) begin
                     st <= S_FIN;
                  end else begin
                     cur_idx <= cur_idx + AW'(1);
                     st      <= S_SEND;
                  end
               end

               S_FIN: begin
                  done <= 1'b1;
                  busy <= 1'b0;
                  pass <= (err_cnt == '0) && !tmo_err && !aborted && !abort;
                  st   <= S_IDLE;
               end

               default: st <= S_IDLE;
            endcase

            // Response scoring; first failure of any kind owns fail_idx
            if (take_resp_c) begin
               cur_bad <= resp_bad_c;
               if (resp_bad_c) begin
                  if (err_cnt == '0)
                     fail_idx <= cur_idx;
                  if (err_cnt != NW'(DEPTH))
                     err_cnt <= err_cnt + NW'(1);
               end
            end

            if (wdog_exp_c) begin
               tmo_err <= 1'b1;
               if (err_cnt == '0)
                  fail_idx <= cur_idx;
            end
         end
      end
   end

endmodule

// File: tb/tb_cmd_seq_player.sv
// Bench for cmd_seq_player: one stop-on-error and one continue-on-error instance
// share the load bus and reset; each has its own control and RemoteComm handshake.
`timescale 1ns/1ps
module tb_cmd_seq_player;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;
   localparam int unsigned NW    = 5;
   localparam int unsigned TMO   = 100;

   logic            clk = 1'b0;
   logic            rst;
   logic            load_we;
   logic [AW-1:0]   load_addr;
   logic [15:0]     load_data;
   logic [NW-1:0]   num_cmds;

   logic            start_v    [2];
   logic            abort_v    [2];
   logic            cmd_snt_v  [2];
   logic            resp_rdy_v [2];
   logic [7:0]      resp_v     [2];
   logic [15:0]     cmd_v      [2];
   logic            snd_v      [2];
   logic            busy_v     [2];
   logic            done_v     [2];
   logic            pass_v     [2];
   logic            tmo_v      [2];
   logic [NW-1:0]   err_v      [2];
   logic [AW-1:0]   fidx_v     [2];
   logic [AW-1:0]   cidx_v     [2];

   logic [15:0]     exp_mem [DEPTH];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cmd_seq_player #(
      .DEPTH(DEPTH), .CMD_W(16), .RESP_W(8), .POS_ACK(8'hA5),
      .TMO_CYC(TMO), .STOP_ON_ERR(1'b1)
   ) u_stop (
      .clk(clk), .rst(rst),
      .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
      .num_cmds(num_cmds), .start(start_v[0]), .abort(abort_v[0]),
      .cmd(cmd_v[0]), .snd_cmd(snd_v[0]),
      .cmd_snt(cmd_snt_v[0]), .resp_rdy(resp_rdy_v[0]), .resp(resp_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
      .err_cnt(err_v[0]), .fail_idx(fidx_v[0]), .tmo_err(tmo_v[0]),
      .cur_idx(cidx_v[0])
   );

   cmd_seq_player #(
      .DEPTH(DEPTH), .CMD_W(16), .RESP_W(8), .POS_ACK(8'hA5),
      .TMO_CYC(TMO), .STOP_ON_ERR(1'b0)
   ) u_cont (
      .clk(clk), .rst(rst),
      .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
      .num_cmds(num_cmds), .start(start_v[1]), .abort(abort_v[1]),
      .cmd(cmd_v[1]), .snd_cmd(snd_v[1]),
      .cmd_snt(cmd_snt_v[1]), .resp_rdy(resp_rdy_v[1]), .resp(resp_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
      .err_cnt(err_v[1]), .fail_idx(fidx_v[1]), .tmo_err(tmo_v[1]),
      .cur_idx(cidx_v[1])
   );

   // One playback scenario: responses for the first four slots, default for the rest
   typedef struct packed {
      int              inst;
      int              num;
      logic [3:0][7:0] rsp;
      logic [7:0]      dflt;
      bit              both;
      int              tmo_at;
      int              exp_sends;
      bit              exp_pass;
      int              exp_err;
      int              exp_fidx;
      bit              exp_tmo;
   } vec_t;

   vec_t vecs [10];

   function automatic vec_t mk(input int inst, input int num,
                               input logic [7:0] r0, input logic [7:0] r1,
                               input logic [7:0] r2, input logic [7:0] r3,
                               input logic [7:0] dflt, input bit both, input int tmo_at,
                               input int es, input bit ep, input int ee,
                               input int ef, input bit et);
      vec_t v;
      v.inst      = inst;
      v.num       = num;
      v.rsp[0]    = r0;
      v.rsp[1]    = r1;
      v.rsp[2]    = r2;
      v.rsp[3]    = r3;
      v.dflt      = dflt;
      v.both      = both;
      v.tmo_at    = tmo_at;
      v.exp_sends = es;
      v.exp_pass  = ep;
      v.exp_err   = ee;
      v.exp_fidx  = ef;
      v.exp_tmo   = et;
      return v;
   endfunction

   function automatic logic [7:0] rsp_of(input vec_t v, input int k);
      if (k < 4)
         return v.rsp[k];
      return v.dflt;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input int i, input string tag);
      chk($sformatf("%s u%0d cmd", tag, i),      int'(cmd_v[i]),  0);
      chk($sformatf("%s u%0d snd_cmd", tag, i),  int'(snd_v[i]),  0);
      chk($sformatf("%s u%0d busy", tag, i),     int'(busy_v[i]), 0);
      chk($sformatf("%s u%0d done", tag, i),     int'(done_v[i]), 0);
      chk($sformatf("%s u%0d pass", tag, i),     int'(pass_v[i]), 0);
      chk($sformatf("%s u%0d err_cnt", tag, i),  int'(err_v[i]),  0);
      chk($sformatf("%s u%0d fail_idx", tag, i), int'(fidx_v[i]), 0);
      chk($sformatf("%s u%0d tmo_err", tag, i),  int'(tmo_v[i]),  0);
      chk($sformatf("%s u%0d cur_idx", tag, i),  int'(cidx_v[i]), 0);
   endtask

   task automatic wait_snd(input int i, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         if (snd_v[i]) ok = 1'b1;
      end
   endtask

   // Start a run, answer every snd_cmd as the scenario says, then score the done pulse
   task automatic run_vec(input int id, input vec_t v, input bit ld, input logic [15:0] ld_data);
      int i, k, guard, lat;
      bit fin;
      i = v.inst; k = 0; guard = 0; lat = -1; fin = 1'b0;
      @(negedge clk);
      num_cmds   = NW'(v.num);
      start_v[i] = 1'b1;
      if (ld) begin
         load_we    = 1'b1;
         load_addr  = '0;
         load_data  = ld_data;
         exp_mem[0] = ld_data;
      end
      @(negedge clk);
      start_v[i] = 1'b0;
      load_we    = 1'b0;
      while (!fin && guard < 400) begin
         if (done_v[i]) begin
            fin = 1'b1;
         end else if (snd_v[i]) begin
            if (k < DEPTH) begin
               chk($sformatf("v%0d cmd%0d", id, k), int'(cmd_v[i]), int'(exp_mem[k]));
               chk($sformatf("v%0d cur_idx%0d", id, k), int'(cidx_v[i]), k);
            end
            chk($sformatf("v%0d busy%0d", id, k), int'(busy_v[i]), 1);
            if (k == v.tmo_at) begin
               lat = 0;
               while (!tmo_v[i] && lat < 200) begin
                  @(negedge clk);
                  lat++;
                  cmd_snt_v[i] = (lat == 1);
               end
               cmd_snt_v[i] = 1'b0;
            end else if (v.both) begin
               @(negedge clk);
               cmd_snt_v[i] = 1'b1; resp_rdy_v[i] = 1'b1; resp_v[i] = rsp_of(v, k);
               @(negedge clk);
               cmd_snt_v[i] = 1'b0; resp_rdy_v[i] = 1'b0;
            end else begin
               @(negedge clk);
               cmd_snt_v[i] = 1'b1;
               @(negedge clk);
               cmd_snt_v[i] = 1'b0; resp_rdy_v[i] = 1'b1; resp_v[i] = rsp_of(v, k);
               @(negedge clk);
               resp_rdy_v[i] = 1'b0;
            end
            k++;
         end
         if (!fin) begin
            @(negedge clk);
            guard++;
         end
      end
      chk($sformatf("v%0d done seen", id), int'(fin), 1);
      chk($sformatf("v%0d sends", id),    k,                v.exp_sends);
      chk($sformatf("v%0d pass", id),     int'(pass_v[i]),  int'(v.exp_pass));
      chk($sformatf("v%0d err_cnt", id),  int'(err_v[i]),   v.exp_err);
      chk($sformatf("v%0d fail_idx", id), int'(fidx_v[i]),  v.exp_fidx);
      chk($sformatf("v%0d tmo_err", id),  int'(tmo_v[i]),   int'(v.exp_tmo));
      chk($sformatf("v%0d busy end", id), int'(busy_v[i]),  0);
      if (v.tmo_at >= 0)
         chk($sformatf("v%0d tmo latency", id), lat, int'(TMO));
   endtask

   initial begin
      bit ok;
      int snd_seen;

      //            inst num  r0     r1     r2     r3     dflt   both tmo sends pass err fidx tmo
      vecs[0] = mk(0,   2,  8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0,  -1, 2,    1,   0,  0,   0);
      vecs[1] = mk(0,   3,  8'hA5, 8'h5A, 8'hA5, 8'hA5, 8'hA5, 0,  -1, 2,    0,   1,  1,   0);
      vecs[2] = mk(1,   3,  8'hA5, 8'h5A, 8'hA5, 8'hA5, 8'hA5, 0,  -1, 3,    0,   1,  1,   0);
      vecs[3] = mk(1,   4,  8'h00, 8'hA5, 8'h5A, 8'hA4, 8'hA5, 1,  -1, 4,    0,   3,  0,   0);
      vecs[4] = mk(0,   4,  8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 1,  -1, 4,    1,   0,  0,   0);
      vecs[5] = mk(0,   3,  8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0,   1, 2,    0,   0,  1,   1);
      vecs[6] = mk(1,   4,  8'h5A, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0,   2, 3,    0,   1,  0,   1);
      vecs[7] = mk(0,  16,  8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 1,  -1, 16,   1,   0,  0,   0);
      vecs[8] = mk(1,  16,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1,  -1, 16,   0,  16,  0,   0);
      vecs[9] = mk(0,   1,  8'h5A, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0,  -1, 1,    0,   1,  0,   0);

      exp_mem[0] = 16'h2000;
      exp_mem[1] = 16'h43F1;
      for (int k = 2; k < DEPTH; k++)
         exp_mem[k] = 16'hC000 + 16'(k * 16'h0111);

      rst = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0; num_cmds = '0;
      for (int i = 0; i < 2; i++) begin
         start_v[i] = 1'b0; abort_v[i] = 1'b0; cmd_snt_v[i] = 1'b0;
         resp_rdy_v[i] = 1'b0; resp_v[i] = '0;
      end
      repeat (3) @(negedge clk);
      chk_zero(0, "reset");
      chk_zero(1, "reset");
      rst = 1'b0;

      for (int k = 0; k < DEPTH; k++) begin
         @(negedge clk);
         load_we = 1'b1; load_addr = AW'(k); load_data = exp_mem[k];
      end
      @(negedge clk);
      load_we = 1'b0;

      for (int n = 0; n < 10; n++)
         run_vec(n, vecs[n], 1'b0, 16'h0);

      // Empty list: done two clocks after the start clock, no strobe
      @(negedge clk);
      num_cmds = '0; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      chk("num0 done early", int'(done_v[0]), 0);
      chk("num0 snd early", int'(snd_v[0]), 0);
      @(negedge clk);
      chk("num0 done", int'(done_v[0]), 1);
      chk("num0 pass", int'(pass_v[0]), 1);
      chk("num0 busy", int'(busy_v[0]), 0);
      chk("num0 snd", int'(snd_v[0]), 0);
      @(negedge clk);
      chk("num0 done width", int'(done_v[0]), 0);

      // Abort in WAIT_RESP with a bad response and a load in the same clock
      @(negedge clk);
      num_cmds = NW'(3); start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      wait_snd(0, ok);
      chk("abort snd0", int'(ok), 1);
      @(negedge clk);
      cmd_snt_v[0] = 1'b1;
      @(negedge clk);
      cmd_snt_v[0] = 1'b0; resp_rdy_v[0] = 1'b1; resp_v[0] = 8'hA5;
      @(negedge clk);
      resp_rdy_v[0] = 1'b0;
      wait_snd(0, ok);
      chk("abort snd1", int'(ok), 1);
      @(negedge clk);
      cmd_snt_v[0] = 1'b1;
      @(negedge clk);
      cmd_snt_v[0] = 1'b0; abort_v[0] = 1'b1; resp_rdy_v[0] = 1'b1; resp_v[0] = 8'h5A;
      load_we = 1'b1; load_addr = '0; load_data = 16'hDEAD;
      @(negedge clk);
      abort_v[0] = 1'b0; resp_rdy_v[0] = 1'b0; load_we = 1'b0;
      chk("abort done early", int'(done_v[0]), 0);
      @(negedge clk);
      chk("abort done", int'(done_v[0]), 1);
      chk("abort pass", int'(pass_v[0]), 0);
      chk("abort err_cnt", int'(err_v[0]), 0);
      chk("abort busy", int'(busy_v[0]), 0);

      // Reset while the restart sits in SEND
      @(negedge clk);
      num_cmds = NW'(2); start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      chk("rst busy before", int'(busy_v[0]), 1);
      rst = 1'b1;
      @(negedge clk);
      chk_zero(0, "midrst");
      rst = 1'b0;
      snd_seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (snd_v[0] || busy_v[0]) snd_seen++;
      end
      chk("post rst activity", snd_seen, 0);

      // Slot 0 must still hold 2000: the busy-time load and reset leave memory alone
      run_vec(10, vecs[0], 1'b0, 16'h0);
      // Same-clock load and start: the new word is played
      run_vec(11, mk(0, 1, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0, -1, 1, 1, 0, 0, 0),
              1'b1, 16'h2001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global time limit: got no end, expected summary");
      $fatal(1);
   end

endmodule
